// File: rtl/tsense_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tsense_pkg
// Description : Shared state encoding and default sizing for the tsense
//               SPI responder.
// Revision    : 1.0 - initial release
// ============================================================================
package tsense_pkg;

    localparam int c_DEFAULT_DW          = 16;
    localparam int c_DEFAULT_CONV_CYCLES = 1024;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tsense_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : tsense_sync_edge
// Description : Two-flop synchronizer plus edge-detect flop; outputs the
//               synchronized level and single-cycle rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tsense_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic SYSCLK,
    input  logic RSTN,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset to the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/tsense_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tsense_spi_slave
// Description : Mode-0 SPI responder emulating the tsense temperature sensor;
//               periodically captures TEMP_IN and shifts it out MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tsense_spi_slave
    import tsense_pkg::*;
#(
    parameter int DW          = c_DEFAULT_DW,
    parameter int CONV_CYCLES = c_DEFAULT_CONV_CYCLES
) (
    input  logic          SYSCLK,
    input  logic          RSTN,
    input  logic          CS,
    input  logic          SCK,
    input  logic [DW-1:0] TEMP_IN,
    output logic          SIO,
    output logic          SIO_OE,
    output logic          FRAME_DONE,
    output logic          SHORT_FRAME
);

    localparam int CW = $clog2(CONV_CYCLES);
    localparam int BW = $clog2(DW + 1);

    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_sck_lvl, w_sck_rise, w_sck_fall;
    logic w_unused;
    logic w_wrap;

    logic [CW-1:0] r_conv_cnt;
    logic [DW-1:0] r_temp;
    logic          r_pending;
    state_t        r_state;
    logic [DW-1:0] r_shreg;
    logic [BW-1:0] r_bitcnt;

    tsense_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .SYSCLK   (SYSCLK),
        .RSTN     (RSTN),
        .async_in (CS),
        .level    (w_cs_lvl),
        .rise     (w_cs_rise),
        .fall     (w_cs_fall)
    );

    tsense_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .SYSCLK   (SYSCLK),
        .RSTN     (RSTN),
        .async_in (SCK),
        .level    (w_sck_lvl),
        .rise     (w_sck_rise),
        .fall     (w_sck_fall)
    );

    // SCK level and rising edge carry no meaning for a mode-0 responder.
    assign w_unused = &{1'b0, w_sck_lvl, w_sck_rise};

    assign w_wrap = (r_conv_cnt == CW'(CONV_CYCLES - 1));

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_conv_cnt <= '0;
            r_temp     <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_conv_cnt <= w_wrap ? '0 : r_conv_cnt + CW'(1);
            if (w_wrap) begin
                if (w_cs_lvl) begin
                    r_temp <= TEMP_IN;
                end else begin
                    r_pending <= 1'b1;
                end
            end
            // A conversion that landed mid-frame is taken once CS releases.
            if (w_cs_rise && r_pending) begin
                r_temp    <= TEMP_IN;
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            SIO         <= 1'b0;
            SIO_OE      <= 1'b0;
            FRAME_DONE  <= 1'b0;
            SHORT_FRAME <= 1'b0;
        end else begin
            FRAME_DONE  <= 1'b0;
            SHORT_FRAME <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state  <= SHIFT;
                        r_shreg  <= r_temp;
                        r_bitcnt <= '0;
                        SIO_OE   <= 1'b1;
                        SIO      <= r_temp[DW-1];
                    end
                end
                SHIFT: begin
                    if (w_cs_rise) begin
                        r_state <= IDLE;
                        SIO_OE  <= 1'b0;
                        SIO     <= 1'b0;
                        // The last bit is sampled on a rise with no trailing fall.
                        if (r_bitcnt >= BW'(DW - 1)) begin
                            FRAME_DONE <= 1'b1;
                        end else begin
                            SHORT_FRAME <= 1'b1;
                        end
                    end else if (w_sck_fall) begin
                        r_shreg <= {r_shreg[DW-2:0], 1'b1};
                        SIO     <= r_shreg[DW-2];
                        if (r_bitcnt != BW'(DW)) begin
                            r_bitcnt <= r_bitcnt + BW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
